train_dispatch: RTL

Downstream companion of the train-stack feasibility checker. It snoops the same order stream the checker receives, waits for the checker's verdict, and for a feasible order replays the stack schedule as a serial push/pop command sequence for the yard controller. For an infeasible order it emits a single fail beat. One transaction is in flight at a time.

---
 rtl/train_dispatch.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/train_dispatch.sv
// Replays a feasible train-stack schedule as serial push/pop beats for the yard
// controller, or emits a single fail beat when the checker rejects the order.
module train_dispatch (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] data,
  input  logic       chk_valid,
  input  logic       chk_result,
  output logic       out_valid,
  output logic       op,
  output logic [3:0] car,
  output logic       last,
  output logic       fail
);

  localparam int MAX_CARS = 10;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_EMIT = 3'd3;
  localparam logic [2:0] S_FAIL = 3'd4;

  logic [2:0] state_q, state_d;
  logic [3:0] n_q, n_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] sp_q, sp_d;
  logic [3:0] next_in_q, next_in_d;

  logic [3:0] order_q [MAX_CARS];
  logic [3:0] stack_q [MAX_CARS];

  logic       order_we, order_clr;
  logic       stack_we;
  logic [3:0] stack_waddr, stack_wdata;

  logic       out_valid_q, out_valid_d;
  logic       op_q, op_d;
  logic [3:0] car_q, car_d;
  logic       last_q, last_d;
  logic       fail_q, fail_d;

  logic       can_pop;
  logic [3:0] top;

  assign top     = (sp_q != 4'd0) ? stack_q[sp_q - 4'd1] : 4'd0;
  assign can_pop = (sp_q != 4'd0) && (top == order_q[idx_q]);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches);
    // combinational logic uses blocking '=', state updates use '<=' below.
    state_d     = state_q;
    n_d         = n_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    sp_d        = sp_q;
    next_in_d   = next_in_q;
    order_we    = 1'b0;
    order_clr   = 1'b0;
    stack_we    = 1'b0;
    stack_waddr = sp_q;
    stack_wdata = next_in_q;
    out_valid_d = 1'b0;
    op_d        = 1'b0;
    car_d       = 4'd0;
    last_d      = 1'b0;
    fail_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          n_d       = data;
          cnt_d     = 4'd0;
          idx_d     = 4'd0;
          sp_d      = 4'd0;
          order_clr = 1'b1;
          state_d   = S_LOAD;
        end
      end

      S_LOAD: begin
        if (in_valid) begin
          order_we = 1'b1;
          cnt_d    = cnt_q + 4'd1;
          if (cnt_q + 4'd1 == n_q) state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        // The first beat is registered on the verdict edge so it appears the very next cycle;
        // a feasible schedule always opens by pushing car 1.
        if (chk_valid) begin
          if (chk_result) begin
            stack_we    = 1'b1;
            stack_waddr = 4'd0;
            stack_wdata = 4'd1;
            sp_d        = 4'd1;
            idx_d       = 4'd0;
            next_in_d   = 4'd2;
            out_valid_d = 1'b1;
            car_d       = 4'd1;
            state_d     = S_EMIT;
          end else begin
            out_valid_d = 1'b1;
            fail_d      = 1'b1;
            last_d      = 1'b1;
            state_d     = S_FAIL;
          end
        end
      end

      S_EMIT: begin
        out_valid_d = 1'b1;
        if (can_pop) begin
          op_d  = 1'b1;
          car_d = order_q[idx_q];
          sp_d  = sp_q - 4'd1;
          idx_d = idx_q + 4'd1;
          if (idx_q + 4'd1 == n_q) begin
            last_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else if (next_in_q <= n_q) begin
          stack_we  = 1'b1;
          car_d     = next_in_q;
          sp_d      = sp_q + 4'd1;
          next_in_d = next_in_q + 4'd1;
        end else begin
          // Only reachable if the checker's verdict was wrong.
          fail_d  = 1'b1;
          last_d  = 1'b1;
          state_d = S_FAIL;
        end
      end

      S_FAIL: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      n_q         <= 4'd0;
      cnt_q       <= 4'd0;
      idx_q       <= 4'd0;
      sp_q        <= 4'd0;
      next_in_q   <= 4'd0;
      out_valid_q <= 1'b0;
      op_q        <= 1'b0;
      car_q       <= 4'd0;
      last_q      <= 1'b0;
      fail_q      <= 1'b0;
      // NOTE: these small buffers are flops, so resetting them is cheap and keeps
      // stale car IDs from ever matching a stack compare after reset.
      for (int i = 0; i < MAX_CARS; i++) begin
        order_q[i] <= 4'd0;
        stack_q[i] <= 4'd0;
      end
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sp_q        <= sp_d;
      next_in_q   <= next_in_d;
      out_valid_q <= out_valid_d;
      op_q        <= op_d;
      car_q       <= car_d;
      last_q      <= last_d;
      fail_q      <= fail_d;
      if (order_clr) begin
        for (int i = 0; i < MAX_CARS; i++) order_q[i] <= 4'd0;
      end else if (order_we) begin
        order_q[cnt_q] <= data;
      end
      if (stack_we) stack_q[stack_waddr] <= stack_wdata;
    end
  end

  assign out_valid = out_valid_q;
  assign op        = op_q;
  assign car       = car_q;
  assign last      = last_q;
  assign fail      = fail_q;

endmodule
